bcd_binary: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: one right-shift plus digit correction per clock.
- Sits on the operand entry path of the multiplier. It turns packed decimal digits from the user/display side into a binary operand for the multiplier core.
- It is the inverse of the binary-to-BCD result path.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_corr.sv | 16 +
 rtl/bcd_binary.sv | 131 +++++++++++++
 tb/tb_bcd_binary.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM states, digit
// constants and a helper giving the minimum binary width for a digit count.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIGIT_W       = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int DD_CORR       = 3;
    localparam int DD_THRESH     = 8;

    // Bits needed to hold 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint v;
        int     w;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        v = v - 1;
        w = 0;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more
// after the right shift gets 3 subtracted.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(DD_THRESH))
            dout = din - DIGIT_W'(DD_CORR);
    end

endmodule

// File: rtl/bcd_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional range check on the result is enabled by BCD_BINARY_RANGE_CHECK_EN.
module bcd_binary
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int MAX_VAL    = 4095
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] BCD_in,
    input  logic                          valid,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_W-1:0]              bin_result,
    output logic                          error,
    output logic                          overflow
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < min_bin_w(NUM_DIGITS)) begin : g_bad_bin_w
        $error("bcd_binary: BIN_W too small for NUM_DIGITS");
    end
    if (MAX_VAL < 0) begin : g_bad_max_val
        $error("bcd_binary: MAX_VAL must be non-negative");
    end

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_reg, bcd_shift, bcd_corr;
    logic [BIN_W-1:0]   acc, acc_shift;
    logic [CNT_W-1:0]   cnt;
    logic               bad_digit;
    logic               last_shift;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_reg[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX_DIGIT))
                bad_digit = 1'b1;
    end

    // BCD LSB drops into the accumulator MSB; digits are then corrected.
    assign bcd_shift  = bcd_reg >> 1;
    assign acc_shift  = {bcd_reg[0], acc[BIN_W-1:1]};
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .din  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
            .dout (bcd_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (valid) state_nxt = CHECK;
            CHECK: begin
                busy      = 1'b1;
                state_nxt = bad_digit ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are written on the edge entering DONE so they are already
    // valid while the done pulse is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_reg    <= '0;
            acc        <= '0;
            cnt        <= '0;
            bin_result <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    bcd_reg <= BCD_in;
                    acc     <= '0;
                    cnt     <= CNT_W'(BIN_W);
                end
                CHECK: if (bad_digit) begin
                    bin_result <= '0;
                    error      <= 1'b1;
                end
                SHIFT: begin
                    bcd_reg <= bcd_corr;
                    acc     <= acc_shift;
                    cnt     <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        bin_result <= acc_shift;
                        error      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_BINARY_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (state == CHECK && bad_digit)
            overflow <= 1'b0;
        else if (last_shift)
            overflow <= (acc_shift > BIN_W'(MAX_VAL));
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_binary.sv
// Directed-vector bench for bcd_binary: latency, results, error path,
// ignored requests and mid-conversion reset.
module tb_bcd_binary;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        valid;
    logic        busy;
    logic        done;
    logic [13:0] bin_result;
    logic        error;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BCD_BINARY_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    bcd_binary dut (
        .clk        (clk),
        .reset      (rst_n),
        .BCD_in     (bcd_in),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .bin_result (bin_result),
        .error      (error),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launch one request and wait for done; returns latency and busy-cycle count.
    task automatic run(input logic [15:0] v, output int lat, output int bcnt);
        @(negedge clk);
        bcd_in = v;
        valid  = 1'b1;
        lat    = 0;
        bcnt   = 0;
        while (lat < 100) begin
            @(negedge clk);
            valid = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        if (!done) chk("timeout", 32'(lat), 32'd16);
    endtask

    int lat, bcnt, ndone;

    initial begin
        rst_n  = 1'b0;
        bcd_in = '0;
        valid  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(bin_result), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'h0045, lat, bcnt);
        chk("0045_latency", 32'(lat), 16);
        chk("0045_busy_cycles", 32'(bcnt), 15);
        chk("0045_result", 32'(bin_result), 45);
        chk("0045_error", 32'(error), 0);

        run(16'h0123, lat, bcnt);
        chk("0123_result", 32'(bin_result), 123);
        run(16'h0999, lat, bcnt);
        chk("0999_result", 32'(bin_result), 999);
        chk("0999_overflow", 32'(overflow), 0);
        run(16'h9999, lat, bcnt);
        chk("9999_result", 32'(bin_result), 9999);
        chk("9999_error", 32'(error), 0);
        chk("9999_overflow", 32'(overflow), 32'(RC));
        repeat (3) @(negedge clk);
        chk("9999_hold", 32'(bin_result), 9999);
        chk("9999_no_done", 32'(done), 0);

        run(16'h0000, lat, bcnt);
        chk("0000_result", 32'(bin_result), 0);

        run(16'h04A5, lat, bcnt);
        chk("04A5_latency", 32'(lat), 2);
        chk("04A5_error", 32'(error), 1);
        chk("04A5_result", 32'(bin_result), 0);
        chk("04A5_overflow", 32'(overflow), 0);

        run(16'h0123, lat, bcnt);
        chk("recover_error", 32'(error), 0);
        chk("recover_result", 32'(bin_result), 123);

        // Second request during SHIFT must be dropped.
        @(negedge clk);
        bcd_in = 16'h2047;
        valid  = 1'b1;
        ndone  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            valid = 1'b0;
            if (c == 5) begin
                bcd_in = 16'h0256;
                valid  = 1'b1;
            end
            if (done) ndone++;
        end
        chk("ignore_done_count", 32'(ndone), 1);
        chk("ignore_result", 32'(bin_result), 2047);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bcd_in = 16'h0999;
        valid  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        chk("async_rst_result", 32'(bin_result), 0);
        chk("async_rst_error", 32'(error), 0);
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("aborted_no_done", 32'(ndone), 0);

        run(16'h0000, lat, bcnt);
        chk("post_rst_latency", 32'(lat), 16);
        chk("post_rst_result", 32'(bin_result), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
